mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 The block SHALL use one clock, clk; reset is synchronous and active-high, port rst, sampled on the rising edge of clk.
REQ-002 Ports (name  direction  width  meaning):
- clk  in  1  clock
- rst  in  1  sync reset, active-high
- flush  in  1  abandon the current access
- ex_reg  in  1  GPR write enable from EX/MEM
- ex_waddr  in  5  GPR destination
- ex_wdata  in  32  ALU result (non-memory ops)
- ex_memop  in  4  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW, 9 LL, 10 SC; codes 11-15 are treated as none
- ex_addr  in  32  effective address
- ex_sdata  in  32  store data
- LLbit_i  in  1  committed LLbit
- wb_LLbit_we  in  1  WB-stage LLbit write, for forwarding
- wb_LLbit_value  in  1  WB-stage LLbit value, for forwarding
- dbus_rdata  in  32  read data
- dbus_ack  in  1  access complete
- dbus_req  out  1  bus request
- dbus_we  out  1  write strobe
- dbus_addr  out  32  word address: ex_addr with bits [1:0] forced to 0
- dbus_sel  out  4  byte lanes
- dbus_wdata  out  32  lane-replicated store data
- stallreq  out  1  stall request to the pipeline controller
- mem_reg  out  1  GPR write enable to MEM/WB
- mem_waddr  out  5  GPR destination to MEM/WB
- mem_wdata  out  32  GPR write data to MEM/WB
- mem_LLbit_we  out  1  LLbit write enable to MEM/WB
- mem_LLbit_value  out  1  LLbit value to MEM/WB
- mem_adel  out  1  load address error
- mem_ades  out  1  store address error

Function
REQ-003 FSM states SHALL be IDLE, WAIT and DONE; the state is registered, and all outputs are combinational from the state, the registered read data and the ex_* inputs.
REQ-004 When ex_memop is none, the block SHALL stay in IDLE and pass through: mem_reg=ex_reg, mem_waddr=ex_waddr, mem_wdata=ex_wdata, stallreq=0, dbus_req=0, LLbit_we=0.
REQ-005 Alignment: a halfword op with addr[0]=1, or a word op (LW, SW, LL, SC) with addr[1:0]!=0, SHALL assert mem_adel (loads, LL) or mem_ades (stores, SC). In that case there is no bus request, mem_reg=0, stallreq=0 and the FSM stays in IDLE.
REQ-006 Effective LLbit SHALL be wb_LLbit_value when wb_LLbit_we=1; otherwise it is LLbit_i.
REQ-007 SC with effective LLbit=0 SHALL perform no bus access, output mem_reg=1 and mem_wdata=0, and complete in IDLE with stallreq=0.
REQ-008 For an aligned access (including SC with effective LLbit=1), the IDLE cycle SHALL assert dbus_req, dbus_we (stores only), dbus_sel and stallreq=1, then go to WAIT.
REQ-009 In WAIT, dbus_req, dbus_we, dbus_addr, dbus_sel, dbus_wdata and stallreq=1 SHALL be held until dbus_ack=1. On the ack edge, dbus_rdata is captured into an internal register and the FSM goes to DONE.
REQ-010 In DONE: dbus_req=0, stallreq=0, and the result is presented to MEM/WB. At the end of DONE the FSM returns to IDLE.
REQ-011 Minimum access latency SHALL be 3 cycles (IDLE, WAIT with ack, DONE); dbus_ack is ignored outside WAIT.
REQ-012 Lane mapping is big-endian:
- Byte: addr[1:0] 00/01/10/11 -> sel 1000/0100/0010/0001, lanes [31:24]/[23:16]/[15:8]/[7:0].
- Halfword: addr[1]=0 -> sel 1100, addr[1]=1 -> sel 0011.
- Word: sel 1111.
- Store data: byte replicated 4x (SB), halfword replicated 2x (SH), word unchanged (SW).
REQ-013 Load result: LB and LH sign-extend the selected lane; LBU and LHU zero-extend it; LW and LL return the full word. mem_reg=ex_reg for loads and 0 for stores.
REQ-014 LL in DONE SHALL output mem_LLbit_we=1, mem_LLbit_value=1.
REQ-015 Successful SC in DONE SHALL output mem_reg=1, mem_wdata=1, mem_LLbit_we=1, mem_LLbit_value=0.
REQ-016 flush=1 SHALL force the FSM to IDLE on the next edge and force dbus_req=0 and stallreq=0 combinationally. A bus ack that arrives after a flush is ignored.
REQ-017 Outputs SHALL be valid to MEM/WB only in the passthrough case (REQ-004), the alignment-error case (REQ-005), the failed-SC case (REQ-007) and DONE. In IDLE-with-request and in WAIT, mem_reg=0 and mem_LLbit_we=0.

Reset
REQ-018 With rst=1, on the next edge the FSM SHALL be IDLE and the captured read data 0. Outputs are then: dbus_req=0, dbus_we=0, dbus_sel=0, stallreq=0, mem_reg=0, mem_waddr=0, mem_wdata=0, mem_LLbit_we=0, mem_adel=0, mem_ades=0.
REQ-019 Reset asserted during WAIT SHALL abandon the access; it does not wait for an ack.

Verification
REQ-020 LB at addr 0x103, dbus_rdata=0x112233F4, ack on the first WAIT cycle -> sel=0001; stallreq high for 2 cycles; DONE outputs mem_wdata=0xFFFFFFF4.
REQ-021 SH at addr 0x202, sdata=0x0000ABCD -> sel=0011, dbus_we=1, dbus_wdata=0xABCDABCD, mem_reg=0.
REQ-022 LW with ack delayed 5 cycles -> bus signals held stable throughout, stallreq=1 for 6 cycles, then DONE returns the read word.
REQ-023 LL, then SC with wb_LLbit_we=1 and wb_LLbit_value=0 -> SC makes no bus access, mem_wdata=0. Repeating with effective LLbit=1 -> bus write occurs, mem_wdata=1, LLbit cleared.
REQ-024 LW at addr 0x3 -> mem_adel=1, dbus_req=0, stallreq=0.
REQ-025 flush asserted in WAIT, then ack arrives -> FSM in IDLE, no DONE output, dbus_req=0; a rst pulse in WAIT has the same result.

Source files
------------

// File: rtl/mem_access.sv
// mem_access: MEM-stage load/store unit with a three-state data bus handshake
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        ex_reg,
  input  logic [4:0]  ex_waddr,
  input  logic [31:0] ex_wdata,
  input  logic [3:0]  ex_memop,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_sdata,
  input  logic        LLbit_i,
  input  logic        wb_LLbit_we,
  input  logic        wb_LLbit_value,
  input  logic [31:0] dbus_rdata,
  input  logic        dbus_ack,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_sel,
  output logic [31:0] dbus_wdata,
  output logic        stallreq,
  output logic        mem_reg,
  output logic [4:0]  mem_waddr,
  output logic [31:0] mem_wdata,
  output logic        mem_LLbit_we,
  output logic        mem_LLbit_value,
  output logic        mem_adel,
  output logic        mem_ades
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t      r_state;
  logic [31:0] r_rdata;
  logic [3:0]  w_op, w_sel;
  logic        w_load, w_store, w_byte, w_half, w_word, w_sc, w_ll;
  logic        w_misal, w_llbit, w_scfail, w_access;
  logic        w_idle, w_done, w_pass, w_err, w_scf, w_bus;
  logic [7:0]  w_b;
  logic [15:0] w_h;
  logic [31:0] w_ld;
  assign w_op     = ex_memop > 4'd10 ? 4'd0 : ex_memop;
  assign w_byte   = w_op == 4'd1 || w_op == 4'd2 || w_op == 4'd6;
  assign w_half   = w_op == 4'd3 || w_op == 4'd4 || w_op == 4'd7;
  assign w_word   = w_op == 4'd5 || w_op >= 4'd8;
  assign w_store  = w_op >= 4'd6 && w_op != 4'd9;
  assign w_load   = w_op != 4'd0 && !w_store;
  assign w_sc     = w_op == 4'd10;
  assign w_ll     = w_op == 4'd9;
  assign w_misal  = (w_half & ex_addr[0]) | (w_word & |ex_addr[1:0]);
  assign w_llbit  = wb_LLbit_we ? wb_LLbit_value : LLbit_i;
  assign w_scfail = w_sc & ~w_llbit;
  assign w_access = (w_load | w_store) & ~w_misal & ~w_scfail;
  assign w_idle   = r_state == IDLE;
  assign w_done   = r_state == DONE;
  assign w_pass   = w_idle & ~w_load & ~w_store;
  assign w_err    = w_idle & w_misal;
  assign w_scf    = w_idle & ~w_misal & w_scfail;
  // Flush and reset kill the bus request immediately, not just at the next edge
  assign w_bus    = ~rst & ~flush & ((w_idle & w_access) | r_state == WAIT);
  assign w_b      = ex_addr[1] ? (ex_addr[0] ? r_rdata[7:0] : r_rdata[15:8])
                               : (ex_addr[0] ? r_rdata[23:16] : r_rdata[31:24]);
  assign w_h      = ex_addr[1] ? r_rdata[15:0] : r_rdata[31:16];
  assign w_ld     = w_op == 4'd1 ? {{24{w_b[7]}}, w_b} :
                    w_op == 4'd2 ? {24'd0, w_b} :
                    w_op == 4'd3 ? {{16{w_h[15]}}, w_h} :
                    w_op == 4'd4 ? {16'd0, w_h} : r_rdata;
  assign w_sel    = w_byte ? 4'b1000 >> ex_addr[1:0] : w_half ? (ex_addr[1] ? 4'b0011 : 4'b1100) : 4'b1111;
  assign dbus_req        = w_bus;
  assign stallreq        = w_bus;
  assign dbus_we         = w_bus & w_store;
  assign dbus_sel        = w_bus ? w_sel : 4'd0;
  assign dbus_addr       = {ex_addr[31:2], 2'b00};
  assign dbus_wdata      = w_byte ? {4{ex_sdata[7:0]}} : w_half ? {2{ex_sdata[15:0]}} : ex_sdata;
  assign mem_reg         = ~rst & (w_pass ? ex_reg : w_scf | (w_done & (w_sc | (w_load & ex_reg))));
  assign mem_waddr       = rst ? 5'd0 : ex_waddr;
  assign mem_wdata       = rst ? 32'd0 : w_pass ? ex_wdata :
                           w_done ? (w_sc ? 32'd1 : w_load ? w_ld : 32'd0) : 32'd0;
  assign mem_LLbit_we    = ~rst & w_done & (w_ll | w_sc);
  assign mem_LLbit_value = ~rst & w_done & w_ll;
  assign mem_adel        = ~rst & w_err & w_load;
  assign mem_ades        = ~rst & w_err & w_store;
  always_ff @(posedge clk) begin
    if (rst) r_rdata <= '0;
    else if (r_state == WAIT && dbus_ack && !flush) r_rdata <= dbus_rdata;
    if (rst || flush) r_state <= IDLE;
    else if (w_idle) r_state <= w_access ? WAIT : IDLE;
    else if (r_state == WAIT) r_state <= dbus_ack ? DONE : WAIT;
    else r_state <= IDLE;
  end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: table vectors, corner sequences and random accesses against a behavioural model
module tb_mem_access;
  logic        clk = 0, rst, flush, ex_reg, LLbit_i, wb_LLbit_we, wb_LLbit_value, dbus_ack;
  logic [4:0]  ex_waddr;
  logic [3:0]  ex_memop;
  logic [31:0] ex_wdata, ex_addr, ex_sdata, dbus_rdata;
  logic        dbus_req, dbus_we, stallreq, mem_reg, mem_LLbit_we, mem_LLbit_value, mem_adel, mem_ades;
  logic [31:0] dbus_addr, dbus_wdata, mem_wdata;
  logic [3:0]  dbus_sel;
  logic [4:0]  mem_waddr;
  int total = 0, bad = 0;

  mem_access dut (
    .clk(clk), .rst(rst), .flush(flush), .ex_reg(ex_reg), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
    .ex_memop(ex_memop), .ex_addr(ex_addr), .ex_sdata(ex_sdata), .LLbit_i(LLbit_i),
    .wb_LLbit_we(wb_LLbit_we), .wb_LLbit_value(wb_LLbit_value), .dbus_rdata(dbus_rdata),
    .dbus_ack(dbus_ack), .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_sel(dbus_sel), .dbus_wdata(dbus_wdata), .stallreq(stallreq), .mem_reg(mem_reg),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_LLbit_we(mem_LLbit_we),
    .mem_LLbit_value(mem_LLbit_value), .mem_adel(mem_adel), .mem_ades(mem_ades)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] op; logic [31:0] addr, sdata, rdata; logic llb, wbwe, wbval; logic [3:0] dly;
  } vin_t;
  // kind: 0 passthrough, 1 alignment error, 2 failed SC, 3 bus access
  typedef struct packed {
    logic [1:0] kind; logic [3:0] sel; logic we; logic [31:0] bwd;
    logic mreg; logic [31:0] mwd; logic llwe, llval, adel, ades;
  } exp_t;
  typedef struct { vin_t i; exp_t e; string nm; } vec_t;
  vec_t tv[$];

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic add(logic [3:0] op, logic [31:0] addr, sdata, rdata, logic llb, wbwe, wbval,
                     logic [3:0] dly, logic [1:0] kind, logic [3:0] sel, logic we, logic [31:0] bwd,
                     logic mreg, logic [31:0] mwd, logic llwe, llval, adel, ades, string nm);
    vec_t v;
    v.i = '{op, addr, sdata, rdata, llb, wbwe, wbval, dly};
    v.e = '{kind, sel, we, bwd, mreg, mwd, llwe, llval, adel, ades};
    v.nm = nm;
    tv.push_back(v);
  endtask

  function automatic exp_t model(vin_t v, logic rg, logic [31:0] wd);
    exp_t e = '0;
    int sz, sh;
    logic [63:0] m, val;
    bit ld = v.op inside {[1:5], 9};
    bit st = v.op inside {[6:8], 10};
    logic llb = v.wbwe ? v.wbval : v.llb;
    sz = v.op inside {1, 2, 6} ? 1 : v.op inside {3, 4, 7} ? 2 : 4;
    if (!ld && !st) begin
      e.mreg = rg; e.mwd = wd; return e;
    end
    if (int'(v.addr[1:0]) % sz != 0) begin
      e.kind = 1; e.adel = ld; e.ades = st; return e;
    end
    if (v.op == 10 && !llb) begin
      e.kind = 2; e.mreg = 1; return e;
    end
    e.kind = 3;
    e.we = st;
    e.sel = sz == 4 ? 4'hF : sz == 2 ? 4'b1100 >> v.addr[1:0] : 4'b1000 >> v.addr[1:0];
    e.bwd = sz == 1 ? {4{v.sdata[7:0]}} : sz == 2 ? {2{v.sdata[15:0]}} : v.sdata;
    sh = 8 * (4 - sz - int'(v.addr[1:0]));
    m = (64'd1 << (8 * sz)) - 64'd1;
    val = ({32'd0, v.rdata} >> sh) & m;
    if ((v.op == 1 || v.op == 3) && val[8 * sz - 1]) val = val | ~m;
    e.mreg = v.op == 10 ? 1'b1 : ld ? rg : 1'b0;
    e.mwd = v.op == 10 ? 32'd1 : ld ? val[31:0] : 32'd0;
    e.llwe = v.op inside {9, 10};
    e.llval = v.op == 9;
    return e;
  endfunction

  task automatic chk_bus(string nm, exp_t e, vin_t v);
    chk({nm, " req"}, dbus_req, 1);
    chk({nm, " stall"}, stallreq, 1);
    chk({nm, " we"}, dbus_we, e.we);
    chk({nm, " sel"}, dbus_sel, e.sel);
    chk({nm, " addr"}, dbus_addr, {v.addr[31:2], 2'b00});
    if (e.we) chk({nm, " bwd"}, dbus_wdata, e.bwd);
    chk({nm, " mreg_hold"}, mem_reg, 0);
    chk({nm, " llwe_hold"}, mem_LLbit_we, 0);
  endtask

  task automatic run(vin_t v, logic rg, logic [31:0] wd, exp_t e, string nm);
    logic [4:0] wa = 5'($urandom);
    int st = 0;
    @(posedge clk); #1;
    ex_memop = v.op; ex_addr = v.addr; ex_sdata = v.sdata; LLbit_i = v.llb;
    wb_LLbit_we = v.wbwe; wb_LLbit_value = v.wbval; ex_reg = rg; ex_wdata = wd; ex_waddr = wa;
    dbus_ack = 1'($urandom); dbus_rdata = $urandom;
    @(negedge clk);
    chk({nm, " waddr"}, mem_waddr, wa);
    if (e.kind != 3) begin
      chk({nm, " req"}, dbus_req, 0);
      chk({nm, " stall"}, stallreq, 0);
      chk({nm, " mreg"}, mem_reg, e.mreg);
      if (e.mreg) chk({nm, " mwd"}, mem_wdata, e.mwd);
      chk({nm, " adel"}, mem_adel, e.adel);
      chk({nm, " ades"}, mem_ades, e.ades);
      chk({nm, " llwe"}, mem_LLbit_we, 0);
    end else begin
      chk_bus({nm, " idle"}, e, v);
      chk({nm, " adel"}, mem_adel | mem_ades, 0);
      if (stallreq) st++;
      for (int k = 0; k <= int'(v.dly); k++) begin
        @(posedge clk); #1;
        dbus_ack = k == int'(v.dly);
        dbus_rdata = dbus_ack ? v.rdata : $urandom;
        @(negedge clk);
        chk_bus({nm, " wait"}, e, v);
        if (stallreq) st++;
      end
      @(posedge clk); #1;
      dbus_ack = 1'($urandom); dbus_rdata = $urandom;
      @(negedge clk);
      chk({nm, " done req"}, dbus_req, 0);
      chk({nm, " done stall"}, stallreq, 0);
      chk({nm, " done mreg"}, mem_reg, e.mreg);
      if (e.mreg) chk({nm, " done mwd"}, mem_wdata, e.mwd);
      chk({nm, " done llwe"}, mem_LLbit_we, e.llwe);
      chk({nm, " done llval"}, mem_LLbit_value, e.llval);
      chk({nm, " stall cycles"}, st, int'(v.dly) + 2);
    end
  endtask

  initial begin
    rst = 1; flush = 0; ex_reg = 1; ex_waddr = 5'h1f; ex_wdata = '1; ex_memop = 4'd5;
    ex_addr = 32'h100; ex_sdata = '1; LLbit_i = 1; wb_LLbit_we = 0; wb_LLbit_value = 0;
    dbus_rdata = '1; dbus_ack = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst req", dbus_req, 0);
    chk("rst we", dbus_we, 0);
    chk("rst sel", dbus_sel, 0);
    chk("rst stall", stallreq, 0);
    chk("rst mreg", mem_reg, 0);
    chk("rst waddr", mem_waddr, 0);
    chk("rst wdata", mem_wdata, 0);
    chk("rst llwe", mem_LLbit_we, 0);
    chk("rst adel", mem_adel, 0);
    chk("rst ades", mem_ades, 0);
    @(posedge clk); #1;
    rst = 0; ex_memop = 0; dbus_ack = 0;

    add(0, 32'h10, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFEF00D, 0, 0, 0, 0, "none");
    add(12, 32'h13, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFEF00D, 0, 0, 0, 0, "op12");
    add(1, 32'h103, 0, 32'h112233F4, 1, 0, 0, 0, 3, 4'b0001, 0, 0, 1, 32'hFFFFFFF4, 0, 0, 0, 0, "lb");
    add(7, 32'h202, 32'h0000ABCD, 0, 1, 0, 0, 1, 3, 4'b0011, 1, 32'hABCDABCD, 0, 0, 0, 0, 0, 0, "sh");
    add(5, 32'h100, 0, 32'h89ABCDEF, 1, 0, 0, 4, 3, 4'hF, 0, 0, 1, 32'h89ABCDEF, 0, 0, 0, 0, "lw_slow");
    add(5, 32'h3, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, "lw_mis");
    add(2, 32'h102, 0, 32'h112233F4, 1, 0, 0, 0, 3, 4'b0010, 0, 0, 1, 32'h00000033, 0, 0, 0, 0, "lbu");
    add(3, 32'h100, 0, 32'h80017FFF, 1, 0, 0, 0, 3, 4'b1100, 0, 0, 1, 32'hFFFF8001, 0, 0, 0, 0, "lh");
    add(4, 32'h102, 0, 32'h80017FFF, 1, 0, 0, 0, 3, 4'b0011, 0, 0, 1, 32'h00007FFF, 0, 0, 0, 0, "lhu");
    add(1, 32'h100, 0, 32'h7F112233, 1, 0, 0, 0, 3, 4'b1000, 0, 0, 1, 32'h0000007F, 0, 0, 0, 0, "lb_pos");
    add(3, 32'h101, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, "lh_mis");
    add(6, 32'h101, 32'h123456A5, 0, 1, 0, 0, 0, 3, 4'b0100, 1, 32'hA5A5A5A5, 0, 0, 0, 0, 0, 0, "sb");
    add(8, 32'h202, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, "sw_mis");
    add(10, 32'h1002, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, "sc_mis");
    add(9, 32'h40, 0, 32'hDEADBEEF, 1, 0, 0, 2, 3, 4'hF, 0, 0, 1, 32'hDEADBEEF, 1, 1, 0, 0, "ll");
    add(10, 32'h44, 32'h55, 0, 1, 1, 0, 0, 2, 0, 0, 0, 1, 0, 0, 0, 0, 0, "sc_fail_fwd");
    add(10, 32'h44, 32'h77665544, 0, 0, 1, 1, 0, 3, 4'hF, 1, 32'h77665544, 1, 1, 1, 0, 0, 0, "sc_ok_fwd");
    add(10, 32'h48, 32'h9, 0, 0, 0, 0, 0, 2, 0, 0, 0, 1, 0, 0, 0, 0, 0, "sc_fail");
    foreach (tv[n]) run(tv[n].i, 1'b1, 32'hCAFEF00D, tv[n].e, tv[n].nm);

    // flush in WAIT, then an ack while flush is still high: the access must not complete
    @(posedge clk); #1;
    ex_memop = 9; ex_addr = 32'h80; ex_reg = 1; LLbit_i = 1; wb_LLbit_we = 0; dbus_ack = 0;
    @(negedge clk);
    chk("fl idle req", dbus_req, 1);
    @(posedge clk); #1;
    flush = 1;
    @(negedge clk);
    chk("fl wait req", dbus_req, 0);
    chk("fl wait stall", stallreq, 0);
    @(posedge clk); #1;
    dbus_ack = 1; dbus_rdata = $urandom;
    @(negedge clk);
    chk("fl ack llwe", mem_LLbit_we, 0);
    chk("fl ack req", dbus_req, 0);
    @(posedge clk); #1;
    flush = 0; dbus_ack = 0;
    @(negedge clk);
    chk("fl after llwe", mem_LLbit_we, 0);
    chk("fl after req", dbus_req, 1);
    @(posedge clk); #1;
    flush = 1; ex_memop = 0;
    @(posedge clk); #1;
    flush = 0;

    // reset pulse in WAIT abandons the access; a fresh access then runs normally
    @(posedge clk); #1;
    ex_memop = 9; ex_addr = 32'h84; dbus_ack = 0;
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    chk("rw req", dbus_req, 0);
    chk("rw stall", stallreq, 0);
    @(posedge clk); #1;
    rst = 0; dbus_ack = 1; dbus_rdata = 32'h13579BDF;
    @(negedge clk);
    chk("rw idle req", dbus_req, 1);
    chk("rw idle llwe", mem_LLbit_we, 0);
    @(posedge clk); #1;
    dbus_ack = 0;
    @(negedge clk);
    chk("rw wait req", dbus_req, 1);
    chk("rw wait llwe", mem_LLbit_we, 0);
    @(posedge clk); #1;
    dbus_ack = 1; dbus_rdata = 32'h2468ACE0;
    @(posedge clk); #1;
    dbus_ack = 0;
    @(negedge clk);
    chk("rw done llwe", mem_LLbit_we, 1);
    chk("rw done mreg", mem_reg, 1);
    chk("rw done mwd", mem_wdata, 32'h2468ACE0);
    @(posedge clk); #1;
    ex_memop = 0;

    for (int n = 0; n < 300; n++) begin
      vin_t v;
      logic rg;
      logic [31:0] wd;
      v.op = 4'($urandom_range(0, 15));
      v.addr = $urandom; v.sdata = $urandom; v.rdata = $urandom;
      v.llb = 1'($urandom); v.wbwe = 1'($urandom); v.wbval = 1'($urandom);
      v.dly = 4'($urandom_range(0, 5));
      rg = 1'($urandom); wd = $urandom;
      run(v, rg, wd, model(v, rg, wd), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
